// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing defaults (27 MHz system clock), word width and controller states.
package ws2812_pkg;

  localparam int GRB_W      = 24;
  localparam int T0H_27M    = 11;
  localparam int T1H_27M    = 22;
  localparam int TBIT_27M   = 33;
  localparam int TRESET_27M = 2048;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

endpackage

// File: rtl/ws2812_serializer.sv
// Shifts one 24-bit GRB word out MSB-first with WS2812 pulse-width coding.
// dout is registered, so the line lags the internal bit phase by one cycle.
module ws2812_serializer
  import ws2812_pkg::*;
#(
  parameter int T0H  = T0H_27M,
  parameter int T1H  = T1H_27M,
  parameter int TBIT = TBIT_27M
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [GRB_W-1:0] grb,
  output logic             dout,
  output logic             word_last
);

  localparam int PW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(TBIT - 1);

  logic [GRB_W-1:0] shreg;
  logic [PW-1:0]    phase;
  logic [4:0]       bit_cnt;
  logic             active;
  logic [PW-1:0]    high_len;

  assign high_len  = shreg[GRB_W-1] ? PW'(T1H) : PW'(T0H);
  assign word_last = active && (bit_cnt == 5'd0) && (phase == PH_LAST);

  // A load in the final cycle of bit 0 restarts the phase seamlessly for the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      dout    <= 1'b0;
    end else begin
      dout <= active && (phase < high_len);
      if (load) begin
        shreg   <= grb;
        bit_cnt <= 5'(GRB_W - 1);
        phase   <= '0;
        active  <= 1'b1;
      end else if (active) begin
        if (phase == PH_LAST) begin
          phase <= '0;
          shreg <= {shreg[GRB_W-2:0], 1'b0};
          if (bit_cnt == 5'd0) active <= 1'b0;
          else bit_cnt <= bit_cnt - 5'd1;
        end else begin
          phase <= phase + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ws2812_chain_ctrl.sv
// WS2812 chain frame controller: pixel register file, refresh scheduling and latch gap.
// Pixels are sampled at load time, so writes to not-yet-loaded pixels show up in the current frame.
module ws2812_chain_ctrl
  import ws2812_pkg::*;
#(
  parameter  int NUM_LEDS = 8,
  parameter  int T0H      = T0H_27M,
  parameter  int T1H      = T1H_27M,
  parameter  int TBIT     = TBIT_27M,
  parameter  int TRESET   = TRESET_27M,
  localparam int AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [GRB_W-1:0] wr_grb,
  input  logic             refresh_req,
  input  logic             auto_refresh,
  output logic             busy,
  output logic             frame_done,
  output logic             WS2812
);

  localparam int GW = (TRESET > 1) ? $clog2(TRESET) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(TRESET - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(NUM_LEDS - 1);

  state_t           state, state_nx;
  logic [GRB_W-1:0] pix [NUM_LEDS];
  logic [AW-1:0]    idx, idx_nx, ld_idx;
  logic [GW-1:0]    gap, gap_nx;
  logic             pending, pending_nx;
  logic             load, word_last;
  logic [GRB_W-1:0] load_grb;

  assign busy     = (state != IDLE);
  assign load_grb = pix[ld_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) pix[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < NUM_LEDS)) begin
      pix[wr_addr] <= wr_grb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LATCH;
      idx        <= '0;
      gap        <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      gap        <= gap_nx;
      pending    <= pending_nx;
      frame_done <= (state == LATCH) && (gap == GAP_LAST);
    end
  end

  // A request arriving in the final latch cycle joins the frame that is about to start.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    gap_nx     = gap;
    pending_nx = pending;
    load       = 1'b0;
    ld_idx     = idx;
    if (state != IDLE && refresh_req) pending_nx = 1'b1;
    case (state)
      IDLE: begin
        if (refresh_req || auto_refresh) begin
          state_nx = LOAD;
          idx_nx   = '0;
        end
      end
      LOAD: begin
        load     = 1'b1;
        ld_idx   = '0;
        state_nx = SEND;
      end
      SEND: begin
        if (word_last) begin
          if (idx == IDX_LAST) begin
            state_nx = LATCH;
            gap_nx   = '0;
          end else begin
            load   = 1'b1;
            ld_idx = idx + 1'b1;
            idx_nx = idx + 1'b1;
          end
        end
      end
      LATCH: begin
        if (gap == GAP_LAST) begin
          gap_nx = '0;
          if (pending || refresh_req || auto_refresh) begin
            state_nx   = LOAD;
            idx_nx     = '0;
            pending_nx = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          gap_nx = gap + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  ws2812_serializer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .grb       (load_grb),
    .dout      (WS2812),
    .word_last (word_last)
  );

endmodule

// File: tb/tb_ws2812_chain_ctrl.sv
// Bench for ws2812_chain_ctrl: frame-timeline reference model checked every cycle,
// a pulse-width decoder on the line, and literal checks of the headline timings.
module tb_ws2812_chain_ctrl;

  localparam int N      = 8;
  localparam int AW     = 3;
  localparam int T0H    = 11;
  localparam int T1H    = 22;
  localparam int TBIT   = 33;
  localparam int TRESET = 2048;
  localparam int WORD   = 24 * TBIT;
  localparam int F      = N * WORD;
  localparam int PERIOD = F + TRESET + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_grb = '0;
  logic          refresh_req = 1'b0;
  logic          auto_refresh = 1'b0;
  logic          busy, frame_done, ws;

  ws2812_chain_ctrl #(
    .NUM_LEDS (N), .T0H (T0H), .T1H (T1H), .TBIT (TBIT), .TRESET (TRESET)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_grb       (wr_grb),
    .refresh_req  (refresh_req),
    .auto_refresh (auto_refresh),
    .busy         (busy),
    .frame_done   (frame_done),
    .WS2812       (ws)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: where we are on the frame timeline, not how the FSM gets there.
  // kind 0 = idle, 1 = frame cycle t (t=0 is the load cycle, t=1..F on the wire), 2 = gap cycle g.
  logic [23:0] m_pix  [N];
  logic [23:0] m_snap [N];
  int          m_kind, m_t, m_g;
  bit          m_pend, m_done, m_start;

  function automatic void model_reset();
    m_kind = 2; m_t = 0; m_g = 0; m_pend = 0; m_done = 0;
    for (int i = 0; i < N; i++) begin
      m_pix[i] = '0;
      m_snap[i] = '0;
    end
  endfunction

  // Line level during frame cycle t is sample t-2; pixel p is captured in cycle p*WORD.
  function automatic bit exp_ws();
    int s, p, b, ph;
    if (m_kind != 1 || m_t < 2) return 1'b0;
    s  = m_t - 2;
    p  = s / WORD;
    b  = 23 - (s / TBIT) % 24;
    ph = s % TBIT;
    return ph < (m_snap[p][b] ? T1H : T0H);
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_done  = 0;
        m_start = 0;
        case (m_kind)
          0: m_start = refresh_req || auto_refresh;
          1: begin
            if (m_t < F && m_t % WORD == 0) m_snap[m_t / WORD] = m_pix[m_t / WORD];
            if (refresh_req) m_pend = 1;
            if (m_t == F) begin m_kind = 2; m_g = 0; end
            else m_t++;
          end
          default: begin
            if (refresh_req) m_pend = 1;
            if (m_g == TRESET - 1) begin
              m_done = 1;
              if (m_pend || auto_refresh) begin m_start = 1; m_pend = 0; end
              else m_kind = 0;
            end else m_g++;
          end
        endcase
        if (m_start) begin m_kind = 1; m_t = 0; end
        if (wr_en && int'(wr_addr) < N) m_pix[wr_addr] = wr_grb;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("ws", ws, exp_ws());
      check("busy", busy, m_kind != 0);
      check("frame_done", frame_done, m_done);
    end
  end

  // Line decoder: classifies each high pulse as a 0 or 1 bit and snapshots a frame at frame_done.
  int          cyc = 0, hi_len, rx_bits, rx_bad, done_cnt = 0;
  int          rx_last_bits, rx_last_bad;
  bit          prev_ws;
  logic [23:0] rx_cur [N];
  logic [23:0] rx_last [N];
  int          done_cyc [$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      hi_len = 0; rx_bits = 0; rx_bad = 0; prev_ws = 0;
      for (int i = 0; i < N; i++) rx_cur[i] = '0;
    end else begin
      if (ws) hi_len++;
      else if (prev_ws) begin
        if (hi_len == T1H || hi_len == T0H) begin
          if (rx_bits < N * 24) rx_cur[rx_bits / 24][23 - rx_bits % 24] = (hi_len == T1H);
        end else rx_bad++;
        rx_bits++;
        hi_len = 0;
      end
      prev_ws = ws;
      if (frame_done) begin
        rx_last = rx_cur; rx_last_bits = rx_bits; rx_last_bad = rx_bad;
        rx_bits = 0; rx_bad = 0;
        done_cnt++;
        done_cyc.push_back(cyc);
      end
    end
  end

  bit rnd_wr = 0, rnd_req = 0;

  task automatic tick(input bit allow_rnd = 1);
    int a;
    if (allow_rnd && rnd_wr) begin
      a = int'($urandom_range(N - 1));
      wr_en   = ($urandom_range(3) == 0) && a != 2 && a != 5;
      wr_addr = AW'(a);
      wr_grb  = $urandom;
    end
    if (allow_rnd && rnd_req) refresh_req = ($urandom_range(299) == 0);
    @(negedge clk);
    #1;
  endtask

  task automatic write_px(input int a, input logic [23:0] v);
    wr_en = 1; wr_addr = AW'(a); wr_grb = v;
    tick(0);
    wr_en = 0;
  endtask

  task automatic pulse_req();
    refresh_req = 1;
    tick(0);
    refresh_req = 0;
  endtask

  task automatic wait_done(input string name, output int waited);
    int start;
    start = done_cnt;
    waited = 0;
    while (done_cnt == start && waited < PERIOD + 200) begin
      tick(1);
      waited++;
    end
    check({name, "_timeout"}, done_cnt != start, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

  int w, d0;

  initial begin
    // Reset release with no traffic: a full gap, one frame_done, then idle.
    repeat (3) tick(0);
    rst_n = 1;
    check("reset_ws", ws, 0);
    check("reset_busy", busy, 1);
    check("reset_frame_done", frame_done, 0);
    wait_done("reset_gap", w);
    check("reset_gap_len", w, TRESET);
    check("idle_after_gap", busy, 0);
    repeat (20) tick(0);
    check("single_done_after_reset", done_cnt, 1);

    // One frame with only pixel 0 = 0x800000.
    write_px(0, 24'h800000);
    pulse_req();
    wait_done("frame_p0", w);
    check("frame_p0_len", w, PERIOD);
    check("frame_p0_bits", rx_last_bits, N * 24);
    check("frame_p0_bad_widths", rx_last_bad, 0);
    check("frame_p0_px0", rx_last[0], 24'h800000);
    for (int i = 1; i < N; i++) check("frame_p0_pxN", rx_last[i], 0);
    check("frame_p0_idle", busy, 0);

    // Random pixel contents, then three requests during SEND coalesce into one extra frame.
    for (int i = 0; i < N; i++) if (i != 2 && i != 5) write_px(i, $urandom);
    rnd_wr = 1;
    pulse_req();
    d0 = done_cnt;
    repeat (100) tick(1);
    pulse_req();
    repeat (1000) tick(1);
    pulse_req();
    repeat (1000) tick(1);
    pulse_req();
    wait_done("coalesce_f1", w);
    wait_done("coalesce_f2", w);
    check("coalesce_spacing", done_cyc[$] - done_cyc[$-1], PERIOD);
    rnd_wr = 0;
    wr_en = 0;
    repeat (TRESET + 100) tick(0);
    check("coalesce_frame_count", done_cnt - d0, 2);
    check("coalesce_idle", busy, 0);

    // Auto refresh with random traffic; late writes to pixels 2 and 5 during pixel 3.
    write_px(2, 24'h5A5A5A);
    auto_refresh = 1;
    rnd_wr = 1;
    rnd_req = 1;
    wait_done("auto_f0", w);
    repeat (2500) tick(1);
    write_px(2, 24'hFFFFFF);
    write_px(5, 24'h00FF00);
    wait_done("auto_f1", w);
    check("auto_spacing_1", done_cyc[$] - done_cyc[$-1], PERIOD);
    check("late_px2_old", rx_last[2], 24'h5A5A5A);
    check("late_px5_current", rx_last[5], 24'h00FF00);
    check("auto_f1_bad_widths", rx_last_bad, 0);
    wait_done("auto_f2", w);
    check("auto_spacing_2", done_cyc[$] - done_cyc[$-1], PERIOD);
    check("late_px2_next", rx_last[2], 24'hFFFFFF);
    check("late_px5_next", rx_last[5], 24'h00FF00);

    // Reset in the middle of SEND while the line is high.
    rnd_wr = 0; rnd_req = 0;
    wr_en = 0; refresh_req = 0; auto_refresh = 0;
    repeat (1000) tick(0);
    w = 0;
    while (ws !== 1'b1 && w < 200) begin
      tick(0);
      w++;
    end
    check("ws_high_before_reset", ws, 1);
    #2 rst_n = 0;
    #1 check("ws_async_clear", ws, 0);
    check("busy_in_reset", busy, 1);
    repeat (3) tick(0);
    rst_n = 1;
    wait_done("midframe_reset_gap", w);
    check("midframe_reset_gap_len", w, TRESET);
    check("midframe_reset_idle", busy, 0);
    repeat (5) tick(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ws2812_chain_ctrl.md
# ws2812_chain_ctrl

Frame controller for a chain of WS2812 LEDs on the single `WS2812` pin. Holds a per-LED GRB register file written by the user logic and schedules refreshes: on request or continuously it streams every pixel MSB-first with WS2812 bit timing, then holds the line low for the latch gap. It sits between the application (colour writes, refresh requests) and the board pin, and replaces the fixed-pattern drivers for the on-board LED.

## Interface
- `NUM_LEDS`, 8: LEDs in the chain, 1..256; `AW = max(1, $clog2(NUM_LEDS))`.
- `T0H`, 11: high cycles for a 0 bit (≈400 ns at 27 MHz).
- `T1H`, 22: high cycles for a 1 bit (≈815 ns).
- `TBIT`, 33: total bit period in cycles; requires `T0H < T1H < TBIT`.
- `TRESET`, 2048: low cycles of the latch gap (≈75 µs, above the 50 µs minimum).

Ports:
- `clk` in 1: system clock (27 MHz).
- `rst_n` in 1: asynchronous active-low reset.
- `wr_en` in 1: pixel write strobe.
- `wr_addr` in AW: pixel index; writes with `wr_addr >= NUM_LEDS` are ignored.
- `wr_grb` in 24: colour, bits [23:16] G, [15:8] R, [7:0] B.
- `refresh_req` in 1: request one frame.
- `auto_refresh` in 1: when high, frames repeat back-to-back.
- `busy` out 1: high in LOAD/SEND/LATCH.
- `frame_done` out 1: one-cycle pulse when a latch gap completes.
- `WS2812` out 1: registered serial data to the LED chain.

## Operation
- States: IDLE, LOAD, SEND, LATCH. Reset state is LATCH with the gap counter at 0, so the chain always sees a full gap before the first frame.
- Reset values: `WS2812`=0, `busy`=1 (LATCH), `frame_done`=0, all pixels 0, pending flag 0, pixel/bit counters 0.
- IDLE: if `refresh_req` or `auto_refresh` is high, go to LOAD with pixel index 0.
- LOAD (1 cycle, first pixel only): copy pixel[0] into the 24-bit shift register, set bit count 23, go to SEND.
- SEND: each bit takes TBIT cycles. `WS2812` is high for T1H cycles (bit 1) or T0H cycles (bit 0), then low for the rest of the period. Shift left after each bit. After bit 0 of pixel k < NUM_LEDS-1, pixel k+1 is loaded in the last cycle of that bit, so there is no idle gap between pixels. After the last pixel, go to LATCH.
- LATCH: `WS2812` stays low for TRESET cycles. In the final cycle `frame_done` pulses, then:
  - to LOAD if the pending flag or `auto_refresh` is set (pending is cleared);
  - otherwise to IDLE.
- `refresh_req` sampled high in LOAD/SEND/LATCH sets the pending flag. Multiple requests coalesce into one frame. The `frame_done` that ends the frame in progress does not acknowledge a request made during that frame.
- Writes are accepted in every state. Each pixel is sampled when it is loaded, so:
  - a write to a pixel already loaded takes effect next frame;
  - a write to a later pixel appears in the current frame;
  - a write in the same cycle as the load of that pixel: the old value is sent.
- Reset mid-frame: `WS2812` drops to 0 immediately, the pixel file clears, and a full TRESET gap follows.

## Timing
- `refresh_req` sampled in IDLE at edge k: LOAD after edge k, first `WS2812` rise at edge k+2.
- Frame length on the wire: NUM_LEDS·24·TBIT cycles, then TRESET cycles low.
- With `auto_refresh` held: frame period is NUM_LEDS·24·TBIT + TRESET + 1 cycles. The +1 is the LOAD cycle.
- `busy` changes on the same edge as the state register. `frame_done` is registered and high in the first cycle the state is IDLE or LOAD after a LATCH.
- Counters: bit-phase counter ≥ $clog2(TBIT) bits, gap counter ≥ $clog2(TRESET) bits, both terminal-compare (no wrap).

## Structure
- Package `ws2812_pkg`:
  - default timing constants for 27 MHz;
  - `GRB_W = 24`;
  - state enum {IDLE, LOAD, SEND, LATCH}.
- Sub-module `ws2812_serializer`:
  - owns the shift register and bit-phase counter;
  - inputs `load`, `grb`; outputs `dout`, `word_last` (final cycle of bit 0).
- The top FSM owns the pixel file, the pixel index, the gap counter and the pending flag.

## Test plan
- Reset release, no requests: `WS2812`=0 and `busy`=1 for 2048 cycles, then `frame_done` pulses once and `busy`=0.
- Write pixel0=0x800000, all others 0, then `refresh_req`:
  - first bit high 22 cycles / low 11;
  - the next 191 bits each high 11 / low 22;
  - then 2048 low cycles and one `frame_done`.
- Three `refresh_req` pulses during SEND: exactly one extra frame after the latch, then IDLE.
- `auto_refresh`=1 for 3 frames: `frame_done` pulses spaced exactly 8·24·33+2048+1 = 8385 cycles apart.
- During pixel 3 of a frame:
  - write pixel 2=0xFFFFFF: the current frame sends the old value, the next frame sends the new one;
  - write pixel 5=0x00FF00: it appears in the current frame.
- `rst_n` low mid-SEND: `WS2812` goes low within the same cycle, and a full 2048-cycle gap follows release.
